hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
- Consumes the 4-bit digit codes produced by the per-digit seg PIO registers and drives the active-low seven-segment HEX outputs of the board.
- Adds registered decoding, a global blink timer, per-digit blink masking and a timed "changed value" highlight blink, so software edits to reverb parameters are visible.
- Sits between the Qsys PIO out_ports and the top-level HEX pins.

Parameters:
- NUM_DIGITS, 6, number of digit lanes.
- BLINK_DIV, 12_500_000, clk cycles per blink half-period (2 Hz blink at 50 MHz).
- HILITE_TOGGLES, 4, blink half-periods a digit highlights after its code changes (range 1..15).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- digit_codes  input  4*NUM_DIGITS  digit i code in bits [4i+3:4i]; digit 0 is least significant.
- blink_mask  input  NUM_DIGITS  1 = digit blinks continuously.
- display_en  input  1  0 = all digits blank; timers keep running.
- hex_n  output  7*NUM_DIGITS  digit i segments {g,f,e,d,c,b,a} in bits [7i+6:7i], active low.

Behaviour:
- Reset: code_q[i] = 4'hF, hl_cnt[i] = 0, blink counter = 0, phase = 1 (on), hex_n = all ones (blank).
- Decode (active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06.
  - F = 7F (blank). The PIO reset value of 15 therefore displays blank.
- Pipeline:
  - Edge k: code_q <= digit_codes.
  - Edge k+1: hex_n <= gated decode(code_q).
  - Latency is 2 clk cycles from input to pin.
- Blink timer:
  - Counter counts 0..BLINK_DIV-1 and wraps.
  - tick = 1 when the counter is at BLINK_DIV-1; phase toggles on tick.
  - The timer is free-running and shared by all lanes.
- Change highlight, per lane:
  - If digit_codes[i] != code_q[i] at an edge, hl_cnt[i] <= HILITE_TOGGLES on that edge.
  - Otherwise, on tick with hl_cnt[i] != 0, hl_cnt[i] decrements.
  - A change coinciding with a tick reloads; there is no decrement on that edge.
  - A change during an active highlight restarts it at the full count.
  - The reset load of 4'hF is not a change; no highlight runs after reset.
- Gating for lane i:
  - blank_i = ~display_en | (phase==0 & (blink_mask[i] | hl_cnt[i]!=0)).
  - When blank_i is set, hex_n lane = 7F; otherwise it is the decoded value.
- Reset mid-operation: all state returns to reset values immediately (asynchronous assertion). Output is blank until 2 cycles after inputs are valid post-deassert.
- No combinational path from any input to hex_n.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - A lane is additionally blanked when its code is 0 and every more-significant lane code is 0 or F.
  - Digit 0 is never suppressed.
  - Evaluated on code_q, so there is no latency change.
- Undefined: zeros are always displayed.

Decomposition:
- Package hex_display_pkg:
  - SEG_BLANK = 7'h7F.
  - 16-entry segment lookup constant array.
  - Typedef seg7_t (7-bit).
  - Typedef code_t (4-bit).
  - HILITE counter width constant (4).
- Sub-module hex_digit_lane, instantiated NUM_DIGITS times:
  - Contains code_q, change detect, hl_cnt, decode and output register.
  - Inputs: tick, phase, display_en, blink bit, suppress flag.
- Blink timer and leading-zero chain stay in the top.

Test Plan:
- Reset with digit_codes = all F -> hex_n = all 7F; after deassert, digit_codes[3:0] = 3 -> hex_n[6:0] = 30 two cycles later (phase on).
- BLINK_DIV = 4, HILITE_TOGGLES = 2, change digit 1 from 5 to 8 -> lane 1 shows 00 / 7F alternating for 2 half-periods, then steady 00; no other lane flickers.
- blink_mask = 6'b000100, digit 2 = E -> lane 2 alternates 06 / 7F every BLINK_DIV cycles indefinitely.
- Change digit 0 on the exact cycle of tick -> hl_cnt = HILITE_TOGGLES (reload, no decrement); second change mid-highlight restarts the full count.
- display_en = 0 with codes 1..6 -> all lanes 7F; re-enable -> decoded values return on the next cycle; assert reset_n mid-highlight -> immediate blank, no highlight afterward.
- LEADING_ZERO_BLANK_EN, codes {F,0,0,4,0,0} (digit 5..0) -> lanes 5..3 blank, lane 2 = 19, lanes 1..0 = 40; all zeros -> only digit 0 = 40.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and the seven-segment lookup for the HEX display controller.
// Segment order is {g,f,e,d,c,b,a}, active low; code 4'hF renders blank.
package hex_display_pkg;

    typedef logic [6:0] seg7_t;
    typedef logic [3:0] code_t;

    localparam int unsigned HL_CNT_W = 4;
    localparam seg7_t SEG_BLANK = 7'h7F;

    localparam seg7_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F
    };

    function automatic seg7_t seg_decode(input code_t code);
        return SEG_LUT[code];
    endfunction

endpackage

// File: rtl/hex_digit_lane.sv
// One display digit: registered code, change-highlight counter,
// gated decode and registered active-low segment output.
module hex_digit_lane
    import hex_display_pkg::*;
#(
    parameter int unsigned HILITE_TOGGLES = 4
)
(
    input  logic  clk,
    input  logic  reset_n,
    input  code_t digit_code,
    input  logic  tick,
    input  logic  phase,
    input  logic  display_en,
    input  logic  blink_en,
    input  logic  suppress,
    output code_t code_q,
    output seg7_t hex_n
);

    localparam logic [HL_CNT_W-1:0] HL_LOAD = HL_CNT_W'(HILITE_TOGGLES);

    code_t               code_d;
    logic [HL_CNT_W-1:0] hl_cnt_q;
    logic [HL_CNT_W-1:0] hl_cnt_d;
    seg7_t               hex_n_q;
    seg7_t               hex_n_d;
    logic                changed_s;
    logic                blank_s;

    // Next-state: a fresh code restarts the highlight even on a tick edge.
    always_comb begin
        code_d    = digit_code;
        changed_s = (digit_code != code_q);
        hl_cnt_d  = hl_cnt_q;
        if (changed_s) begin
            hl_cnt_d = HL_LOAD;
        end else if (tick && (hl_cnt_q != {HL_CNT_W{1'b0}})) begin
            hl_cnt_d = hl_cnt_q - {{(HL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            hl_cnt_d = hl_cnt_q;
        end
        blank_s = ~display_en | suppress
                | (~phase & (blink_en | (hl_cnt_q != {HL_CNT_W{1'b0}})));
        if (blank_s) begin
            hex_n_d = SEG_BLANK;
        end else begin
            hex_n_d = seg_decode(code_q);
        end
    end

    // Lane state registers; reset code 4'hF shows blank and starts no highlight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            code_q   <= 4'hF;
            hl_cnt_q <= {HL_CNT_W{1'b0}};
            hex_n_q  <= SEG_BLANK;
        end else begin
            code_q   <= code_d;
            hl_cnt_q <= hl_cnt_d;
            hex_n_q  <= hex_n_d;
        end
    end

    assign hex_n = hex_n_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// HEX display controller: shared blink timer, optional leading-zero
// suppression (LEADING_ZERO_BLANK_EN) and NUM_DIGITS registered lanes.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 6,
    parameter int unsigned BLINK_DIV      = 12_500_000,
    parameter int unsigned HILITE_TOGGLES = 4
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digit_codes,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    display_en,
    output logic [7*NUM_DIGITS-1:0] hex_n
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB_ON = 1'b1;
`else
    localparam logic LZB_ON = 1'b0;
`endif

    logic [CNT_W-1:0]      blink_cnt_q;
    logic [CNT_W-1:0]      blink_cnt_d;
    logic                  phase_q;
    logic                  phase_d;
    logic                  tick_s;
    code_t                 lane_code_s [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] suppress_s;
    logic                  clear_v;

    // Free-running half-period counter; phase flips on each wrap.
    always_comb begin
        tick_s = (blink_cnt_q == CNT_LAST);
        if (tick_s) begin
            blink_cnt_d = {CNT_W{1'b0}};
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            phase_d     = phase_q;
        end
    end

    // Blink timer registers; phase starts in the "on" half.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= {CNT_W{1'b0}};
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // A zero is leading when every higher lane holds 0 or blank; lane 0 always shows.
    always_comb begin
        suppress_s = {NUM_DIGITS{1'b0}};
        clear_v    = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            clear_v = (lane_code_s[i] == 4'h0);
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                clear_v = clear_v & ((lane_code_s[j] == 4'h0) | (lane_code_s[j] == 4'hF));
            end
            suppress_s[i] = LZB_ON & clear_v;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        hex_digit_lane #(
            .HILITE_TOGGLES (HILITE_TOGGLES)
        ) u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .digit_code (digit_codes[4*g +: 4]),
            .tick       (tick_s),
            .phase      (phase_q),
            .display_en (display_en),
            .blink_en   (blink_mask[g]),
            .suppress   (suppress_s[g]),
            .code_q     (lane_code_s[g]),
            .hex_n      (hex_n[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: time-based reference model compared every cycle,
// plus hand-computed literal checks. Define LEADING_ZERO_BLANK_EN to match the RTL build.
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int D  = 4;
    localparam int H  = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [23:0]   digit_codes;
    logic [5:0]    blink_mask;
    logic          display_en;
    logic [41:0]   hex_n;

    logic [41:0]   exp_hex = {42{1'b1}};
    int            e;
    int            code_m [ND];
    int            lc [ND];
    int            m_hl;
    bit            m_ph;
    bit            m_blank;
    int            n_cmp = 0;
    int            n_bad = 0;

    hex_display_ctrl #(
        .NUM_DIGITS     (ND),
        .BLINK_DIV      (D),
        .HILITE_TOGGLES (H)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_codes (digit_codes),
        .blink_mask  (blink_mask),
        .display_en  (display_en),
        .hex_n       (hex_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int c);
        case (c)
            0:  return 7'h40;  1:  return 7'h79;  2:  return 7'h24;  3:  return 7'h30;
            4:  return 7'h19;  5:  return 7'h12;  6:  return 7'h02;  7:  return 7'h78;
            8:  return 7'h00;  9:  return 7'h10;  10: return 7'h08;  11: return 7'h03;
            12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  default: return 7'h7F;
        endcase
    endfunction

    function automatic bit lz_sup(input int i);
        if (i == 0 || code_m[i] != 0) return 1'b0;
        for (int j = i + 1; j < ND; j++)
            if (code_m[j] != 0 && code_m[j] != 15) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference model: e = edges since reset; phase and highlight follow from e.
    initial begin : model
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                e = 0;
                for (int i = 0; i < ND; i++) begin
                    code_m[i] = 15;
                    lc[i]     = -1;
                end
                exp_hex = {42{1'b1}};
            end else begin
                m_ph = ((e / D) % 2) == 0;
                for (int i = 0; i < ND; i++) begin
                    m_hl = (lc[i] < 0) ? 0 : H - (e / D - lc[i] / D);
                    if (m_hl < 0) m_hl = 0;
                    m_blank = !display_en || (!m_ph && (blink_mask[i] || m_hl > 0));
`ifdef LEADING_ZERO_BLANK_EN
                    if (lz_sup(i)) m_blank = 1'b1;
`endif
                    exp_hex[7*i +: 7] = m_blank ? 7'h7F : seg_of(code_m[i]);
                end
                e++;
                for (int i = 0; i < ND; i++) begin
                    if (int'(digit_codes[4*i +: 4]) != code_m[i]) begin
                        code_m[i] = int'(digit_codes[4*i +: 4]);
                        lc[i]     = e;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, just after each active edge.
    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            chk("model", hex_n, exp_hex);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_code(input int lane, input logic [3:0] v);
        digit_codes[4*lane +: 4] = v;
    endtask

    initial begin : stim
        int k;
        reset_n     = 1'b0;
        digit_codes = {24{1'b1}};
        blink_mask  = 6'b000000;
        display_en  = 1'b1;
        cyc(3);
        chk("reset_blank", hex_n, {42{1'b1}});

        // Release and show a 3: visible two edges later, then highlight blinks.
        reset_n = 1'b1;
        set_code(0, 4'h3);
        cyc(2);
        chk("d0_three", {35'd0, hex_n[6:0]}, {35'd0, 7'h30});
        cyc(4);
        chk("d0_hl_blank", {35'd0, hex_n[6:0]}, {35'd0, 7'h7F});
        cyc(8);
        chk("d0_hl_done", hex_n, {{35{1'b1}}, 7'h30});

        // Lane 1 change 5 -> 8.
        set_code(1, 4'h5);
        cyc(16);
        set_code(1, 4'h8);
        cyc(20);

        // Continuous blink on lane 2.
        blink_mask = 6'b000100;
        set_code(2, 4'hE);
        cyc(24);
        blink_mask = 6'b000000;
        cyc(4);

        // Change lane 0 on the tick edge, then restart mid-highlight.
        k = 0;
        while (((e % D) != D - 1) && (k < 10)) begin
            cyc(1);
            k++;
        end
        set_code(0, 4'h7);
        cyc(3);
        set_code(0, 4'h9);
        cyc(20);

        // Display enable gating with codes 1..6.
        digit_codes = 24'h654321;
        cyc(16);
        display_en = 1'b0;
        cyc(1);
        chk("disp_off", hex_n, {42{1'b1}});
        display_en = 1'b1;
        cyc(1);
        chk("disp_on", hex_n, {7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79});

        // Asynchronous reset during a highlight.
        set_code(3, 4'h0);
        cyc(2);
        reset_n     = 1'b0;
        digit_codes = {24{1'b1}};
        #1;
        chk("async_reset", hex_n, {42{1'b1}});
        cyc(2);
        reset_n = 1'b1;
        cyc(12);
        chk("post_reset_quiet", hex_n, {42{1'b1}});

        // Leading-zero behaviour.
        digit_codes = 24'hF00400;
        cyc(16);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lzb_mixed", hex_n, {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h40, 7'h40});
`else
        chk("lzb_mixed", hex_n, {7'h7F, 7'h40, 7'h40, 7'h19, 7'h40, 7'h40});
`endif
        digit_codes = 24'h000000;
        cyc(16);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lzb_zeros", hex_n, {{35{1'b1}}, 7'h40});
`else
        chk("lzb_zeros", hex_n, {6{7'h40}});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
